// File: rtl/div_pkg.sv
// div_pkg: shared sizing functions, default tan80/tan100 clamp constants and saturation helper for div_pipe
package div_pkg;
  localparam logic [19:0] CLAMP_MAX_DEF = 20'h5ABD9;
  localparam logic [19:0] CLAMP_MIN_DEF = 20'hA5426;
  function automatic int q_w(int a_w, int f_w);
    return a_w + f_w;
  endfunction
  function automatic int n_stg(int qw, int bps);
    return (qw + bps - 1) / bps;
  endfunction
  function automatic logic [63:0] sat_max(int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction
endpackage

// File: rtl/div_pipe_if.sv
// div_pipe_if: div_pipe sample bus (en, i_valid/i_a/i_b/i_tag in; o_valid/o/o_tag/o_div0/o_busy out) with master/slave modports
interface div_pipe_if #(
  parameter int A_W = 9,
  parameter int B_W = 9,
  parameter int O_W = 20,
  parameter int TAG_W = 8
);
  logic en;
  logic i_valid;
  logic [A_W-1:0] i_a;
  logic [B_W-1:0] i_b;
  logic [TAG_W-1:0] i_tag;
  logic o_valid;
  logic [O_W-1:0] o;
  logic [TAG_W-1:0] o_tag;
  logic o_div0;
  logic o_busy;
  modport master (output en, i_valid, i_a, i_b, i_tag, input o_valid, o, o_tag, o_div0, o_busy);
  modport slave (input en, i_valid, i_a, i_b, i_tag, output o_valid, o, o_tag, o_div0, o_busy);
endinterface

// File: rtl/div_pipe_stage.sv
// div_pipe_stage: BPS restoring-division steps per stage; q carries remaining dividend bits on top and quotient bits shifting in below
module div_pipe_stage #(
  parameter int BPS = 2,
  parameter int B_W = 9,
  parameter int Q_W = 26,
  parameter int TAG_W = 8
)(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic [B_W:0] rem_i,
  output logic [B_W:0] rem_o,
  input  logic [B_W-1:0] div_i,
  output logic [B_W-1:0] div_o,
  input  logic [Q_W-1:0] q_i,
  output logic [Q_W-1:0] q_o,
  input  logic valid_i,
  output logic valid_o,
  input  logic [TAG_W-1:0] tag_i,
  output logic [TAG_W-1:0] tag_o,
  input  logic sign_i,
  output logic sign_o,
  input  logic div0_i,
  output logic div0_o
);
  logic [B_W:0] r;
  logic [Q_W-1:0] q;
  logic ge;
  always_comb begin
    r = rem_i;
    q = q_i;
    ge = 1'b0;
    for (int i = 0; i < BPS; i++) begin
      r = {r[B_W-1:0], q[Q_W-1]};
      ge = r >= {1'b0, div_i};
      r = ge ? r - {1'b0, div_i} : r;
      q = {q[Q_W-2:0], ge};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) valid_o <= 1'b0;
    else if (en) valid_o <= valid_i;
  end
  always_ff @(posedge clk) begin
    if (en) begin
      rem_o <= r;
      div_o <= div_i;
      q_o <= q;
      tag_o <= tag_i;
      sign_o <= sign_i;
      div0_o <= div0_i;
    end
  end
endmodule

// File: rtl/div_pipe.sv
// div_pipe: pipelined signed fixed-point divider o = a / b with div0/overflow saturation; clk, rst, bus (div_pipe_if.slave); DIV_PIPE_CLAMP_EN enables output clamp
module div_pipe import div_pkg::*; #(
  parameter int A_W = 9,
  parameter int B_W = 9,
  parameter int O_I_W = 4,
  parameter int O_F_W = 16,
  parameter int BPS = 2,
  parameter int TAG_W = 8,
  parameter logic [O_I_W+O_F_W-1:0] CLAMP_MAX = CLAMP_MAX_DEF,
  parameter logic [O_I_W+O_F_W-1:0] CLAMP_MIN = CLAMP_MIN_DEF
)(
  input logic clk,
  input logic rst,
  div_pipe_if.slave bus
);
  localparam int O_W = O_I_W + O_F_W;
  localparam int Q_W = q_w(A_W, O_F_W);
  localparam int N_STG = n_stg(Q_W, BPS);
  localparam int P_W = N_STG * BPS;
  localparam logic [O_W-1:0] SAT = O_W'(sat_max(O_W));
`ifdef DIV_PIPE_CLAMP_EN
  localparam bit CLAMP_ON = 1'b1;
`else
  localparam bit CLAMP_ON = 1'b0;
`endif
  logic [A_W-1:0] a_abs_q;
  logic [B_W-1:0] b_abs_q;
  logic sign_q, div0_q, v0_q;
  logic [TAG_W-1:0] tag0_q;
  logic [B_W:0] rem [N_STG+1];
  logic [B_W-1:0] dv [N_STG+1];
  logic [P_W-1:0] qp [N_STG+1];
  logic [TAG_W-1:0] tg [N_STG+1];
  logic [N_STG:0] vl, sg, dz;
  logic [O_W-1:0] mag, res_d, res_q, clp_d, o_q;
  logic [TAG_W-1:0] rtag_q, otag_q;
  logic rdz_q, rv_q, ov_q, odz_q;
  logic unused_ok;
  always_ff @(posedge clk) begin
    if (rst) v0_q <= 1'b0;
    else if (bus.en) v0_q <= bus.i_valid;
  end
  // a zero divisor has no quotient sign, so the sign flag carries the dividend sign instead
  always_ff @(posedge clk) begin
    if (bus.en) begin
      a_abs_q <= bus.i_a[A_W-1] ? -bus.i_a : bus.i_a;
      b_abs_q <= bus.i_b[B_W-1] ? -bus.i_b : bus.i_b;
      div0_q <= bus.i_b == '0;
      sign_q <= (bus.i_b == '0) ? bus.i_a[A_W-1] : bus.i_a[A_W-1] ^ bus.i_b[B_W-1];
      tag0_q <= bus.i_tag;
    end
  end
  assign rem[0] = '0;
  assign dv[0] = b_abs_q;
  assign qp[0] = P_W'({a_abs_q, O_F_W'(0)});
  assign tg[0] = tag0_q;
  assign vl[0] = v0_q;
  assign sg[0] = sign_q;
  assign dz[0] = div0_q;
  for (genvar g = 0; g < N_STG; g++) begin : g_stg
    div_pipe_stage #(.BPS(BPS), .B_W(B_W), .Q_W(P_W), .TAG_W(TAG_W)) u_stg (
      .clk(clk), .rst(rst), .en(bus.en),
      .rem_i(rem[g]), .rem_o(rem[g+1]),
      .div_i(dv[g]), .div_o(dv[g+1]),
      .q_i(qp[g]), .q_o(qp[g+1]),
      .valid_i(vl[g]), .valid_o(vl[g+1]),
      .tag_i(tg[g]), .tag_o(tg[g+1]),
      .sign_i(sg[g]), .sign_o(sg[g+1]),
      .div0_i(dz[g]), .div0_o(dz[g+1])
    );
  end
  assign unused_ok = ^{rem[N_STG], dv[N_STG]};
  assign mag = (dz[N_STG] || 64'(qp[N_STG]) > sat_max(O_W)) ? SAT : O_W'(qp[N_STG]);
  assign res_d = sg[N_STG] ? -mag : mag;
  assign clp_d = !CLAMP_ON ? res_q :
                 $signed(res_q) > $signed(CLAMP_MAX) ? CLAMP_MAX :
                 $signed(res_q) < $signed(CLAMP_MIN) ? CLAMP_MIN : res_q;
  always_ff @(posedge clk) begin
    if (bus.en) begin
      res_q <= res_d;
      rtag_q <= tg[N_STG];
      rdz_q <= dz[N_STG];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rv_q <= 1'b0;
      ov_q <= 1'b0;
    end else if (bus.en) begin
      rv_q <= vl[N_STG];
      ov_q <= rv_q;
    end
  end
  // output data only loads on a valid result so it holds between results
  always_ff @(posedge clk) begin
    if (rst) begin
      o_q <= '0;
      otag_q <= '0;
      odz_q <= 1'b0;
    end else if (bus.en && rv_q) begin
      o_q <= clp_d;
      otag_q <= rtag_q;
      odz_q <= rdz_q;
    end
  end
  assign bus.o_valid = ov_q;
  assign bus.o = o_q;
  assign bus.o_tag = otag_q;
  assign bus.o_div0 = odz_q;
  assign bus.o_busy = |vl | rv_q | ov_q;
endmodule
